// File: rtl/trigger_capture_pkg.sv
// Shared state encodings and default widths for the trigger capture sequencer.
package trigger_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READOUT = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int CONFIRM_W_DEF = 4;
  localparam int POST_W_DEF    = 16;
  localparam int HOLD_W_DEF    = 24;
  localparam int EVT_W_DEF     = 16;

endpackage

// File: rtl/frame_hit_qualifier.sv
// Sticky per-frame hit flag and consecutive-hit-frame counter; emits a
// combinational confirm pulse on the frame_done that reaches the target.
module frame_hit_qualifier
  import trigger_capture_pkg::*;
#(
  parameter int CONFIRM_W = CONFIRM_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 t_valid,
  input  logic                 trig_hit,
  input  logic                 frame_done,
  input  logic [CONFIRM_W-1:0] cfg_confirm_frames,
  output logic                 confirm
);

  logic                 frame_hit_q, frame_hit_d;
  logic [CONFIRM_W-1:0] confirm_cnt_q, confirm_cnt_d;
  logic [CONFIRM_W-1:0] cnt_inc;
  logic [CONFIRM_W-1:0] target;
  logic                 beat_hit;
  logic                 hit_now;

  always_comb begin
    beat_hit      = t_valid & trig_hit;
    // A hit on the frame_done beat belongs to the frame that is closing.
    hit_now       = frame_hit_q | beat_hit;
    cnt_inc       = (&confirm_cnt_q) ? confirm_cnt_q : confirm_cnt_q + 1'b1;
    target        = (cfg_confirm_frames == '0) ? CONFIRM_W'(1) : cfg_confirm_frames;
    frame_hit_d   = frame_hit_q;
    confirm_cnt_d = confirm_cnt_q;
    confirm       = 1'b0;
    if (clear) begin
      frame_hit_d   = 1'b0;
      confirm_cnt_d = '0;
    end else if (enable) begin
      if (frame_done) begin
        frame_hit_d = 1'b0;
        if (hit_now) begin
          confirm_cnt_d = cnt_inc;
          confirm       = (cnt_inc >= target);
        end else begin
          confirm_cnt_d = '0;
        end
      end else if (beat_hit) begin
        frame_hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_hit_q   <= 1'b0;
      confirm_cnt_q <= '0;
    end else begin
      frame_hit_q   <= frame_hit_d;
      confirm_cnt_q <= confirm_cnt_d;
    end
  end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Arm / qualify / post-trigger capture / readout / hold-off sequencer
// controlling the hydrophone sample ring buffer.
module trigger_capture_ctrl
  import trigger_capture_pkg::*;
#(
  parameter int CONFIRM_W = CONFIRM_W_DEF,
  parameter int POST_W    = POST_W_DEF,
  parameter int HOLD_W    = HOLD_W_DEF,
  parameter int EVT_W     = EVT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 auto_rearm,
  input  logic [CONFIRM_W-1:0] cfg_confirm_frames,
  input  logic [POST_W-1:0]    cfg_post_samples,
  input  logic [HOLD_W-1:0]    cfg_holdoff_cycles,
  input  logic                 t_valid,
  input  logic                 trig_hit,
  input  logic                 frame_done,
  input  logic                 sample_valid,
  input  logic                 readout_done,
  output logic                 capture_start,
  output logic                 buf_freeze,
  output logic                 readout_req,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [EVT_W-1:0]     event_count
);

  state_t               state_q, state_d;
  logic [CONFIRM_W-1:0] cfg_confirm_q, cfg_confirm_d;
  logic [POST_W-1:0]    cfg_post_q, cfg_post_d;
  logic [HOLD_W-1:0]    cfg_hold_q, cfg_hold_d;
  logic                 cfg_rearm_q, cfg_rearm_d;
  logic [POST_W-1:0]    post_cnt_q, post_cnt_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [EVT_W-1:0]     event_count_q, event_count_d;
  logic                 capture_start_q, capture_start_d;
  logic                 buf_freeze_q, buf_freeze_d;
  logic                 readout_req_q, readout_req_d;
  logic                 busy_q, busy_d;

  logic                 confirm;
  logic                 qual_clear;
  logic                 qual_enable;
  logic [POST_W-1:0]    post_next;
  logic [HOLD_W:0]      hold_next;
  logic                 hold_done;

  assign qual_clear  = (state_q != ST_ARMED) | abort;
  assign qual_enable = (state_q == ST_ARMED);

  frame_hit_qualifier #(
    .CONFIRM_W (CONFIRM_W)
  ) u_qual (
    .clk                (clk),
    .reset              (reset),
    .clear              (qual_clear),
    .enable             (qual_enable),
    .t_valid            (t_valid),
    .trig_hit           (trig_hit),
    .frame_done         (frame_done),
    .cfg_confirm_frames (cfg_confirm_q),
    .confirm            (confirm)
  );

  always_comb begin
    post_next     = post_cnt_q + POST_W'(sample_valid);
    hold_next     = {1'b0, hold_cnt_q} + 1'b1;
    // A zero hold-off still spends one cycle in HOLDOFF.
    hold_done     = (hold_next >= {1'b0, cfg_hold_q});

    state_d       = state_q;
    cfg_confirm_d = cfg_confirm_q;
    cfg_post_d    = cfg_post_q;
    cfg_hold_d    = cfg_hold_q;
    cfg_rearm_d   = cfg_rearm_q;
    post_cnt_d    = post_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    event_count_d = event_count_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d       = ST_ARMED;
          cfg_confirm_d = cfg_confirm_frames;
          cfg_post_d    = cfg_post_samples;
          cfg_hold_d    = cfg_holdoff_cycles;
          cfg_rearm_d   = auto_rearm;
        end
      end
      ST_ARMED: begin
        if (confirm) begin
          state_d    = ST_CAPTURE;
          post_cnt_d = '0;
          if (!(&event_count_q)) event_count_d = event_count_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        post_cnt_d = post_next;
        // Second term covers a zero target, which exits without any strobe.
        if ((post_next == cfg_post_q) || (post_cnt_q == cfg_post_q)) begin
          state_d = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (readout_done) begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = '0;
        end
      end
      ST_HOLDOFF: begin
        hold_cnt_d = hold_next[HOLD_W-1:0];
        if (hold_done) begin
          state_d    = cfg_rearm_q ? ST_ARMED : ST_IDLE;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d       = ST_IDLE;
      post_cnt_d    = '0;
      hold_cnt_d    = '0;
      event_count_d = event_count_q;
    end

    capture_start_d = (state_d == ST_CAPTURE) && (state_q != ST_CAPTURE);
    buf_freeze_d    = (state_d == ST_READOUT);
    readout_req_d   = (state_d == ST_READOUT);
    busy_d          = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cfg_confirm_q   <= '0;
      cfg_post_q      <= '0;
      cfg_hold_q      <= '0;
      cfg_rearm_q     <= 1'b0;
      post_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      event_count_q   <= '0;
      capture_start_q <= 1'b0;
      buf_freeze_q    <= 1'b0;
      readout_req_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg_confirm_q   <= cfg_confirm_d;
      cfg_post_q      <= cfg_post_d;
      cfg_hold_q      <= cfg_hold_d;
      cfg_rearm_q     <= cfg_rearm_d;
      post_cnt_q      <= post_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      event_count_q   <= event_count_d;
      capture_start_q <= capture_start_d;
      buf_freeze_q    <= buf_freeze_d;
      readout_req_q   <= readout_req_d;
      busy_q          <= busy_d;
    end
  end

  assign state         = state_q;
  assign capture_start = capture_start_q;
  assign buf_freeze    = buf_freeze_q;
  assign readout_req   = readout_req_q;
  assign busy          = busy_q;
  assign event_count   = event_count_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed bench for trigger_capture_ctrl with hand-computed expectations.
module tb_trigger_capture_ctrl;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        abort;
  logic        auto_rearm;
  logic [3:0]  cfg_confirm_frames;
  logic [15:0] cfg_post_samples;
  logic [23:0] cfg_holdoff_cycles;
  logic        t_valid;
  logic        trig_hit;
  logic        frame_done;
  logic        sample_valid;
  logic        readout_done;
  logic        capture_start;
  logic        buf_freeze;
  logic        readout_req;
  logic        busy;
  logic [2:0]  state;
  logic [15:0] event_count;

  int unsigned n_tests;
  int unsigned n_fail;

  trigger_capture_ctrl #(
    .CONFIRM_W (4),
    .POST_W    (16),
    .HOLD_W    (24),
    .EVT_W     (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .arm                (arm),
    .abort              (abort),
    .auto_rearm         (auto_rearm),
    .cfg_confirm_frames (cfg_confirm_frames),
    .cfg_post_samples   (cfg_post_samples),
    .cfg_holdoff_cycles (cfg_holdoff_cycles),
    .t_valid            (t_valid),
    .trig_hit           (trig_hit),
    .frame_done         (frame_done),
    .sample_valid       (sample_valid),
    .readout_done       (readout_done),
    .capture_start      (capture_start),
    .buf_freeze         (buf_freeze),
    .readout_req        (readout_req),
    .busy               (busy),
    .state              (state),
    .event_count        (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm(input logic [3:0] conf, input logic [15:0] post,
                           input logic [23:0] hold, input logic rearm);
    cfg_confirm_frames = conf;
    cfg_post_samples   = post;
    cfg_holdoff_cycles = hold;
    auto_rearm         = rearm;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // One frame: a beat carrying the hit (or not), an idle beat, then frame_done.
  task automatic frame(input logic hit);
    t_valid = 1'b1; trig_hit = hit;
    step();
    t_valid = 1'b0; trig_hit = 1'b0;
    step();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  task automatic strobe();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_readout_done();
    readout_done = 1'b1;
    step();
    readout_done = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; auto_rearm = 1'b0;
    cfg_confirm_frames = '0; cfg_post_samples = '0; cfg_holdoff_cycles = '0;
    t_valid = 1'b0; trig_hit = 1'b0; frame_done = 1'b0;
    sample_valid = 1'b0; readout_done = 1'b0;
    repeat (3) step();
    check("rst_state", 32'(state), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_freeze", 32'(buf_freeze), 0);
    check("rst_req", 32'(readout_req), 0);
    check("rst_cstart", 32'(capture_start), 0);
    check("rst_evt", 32'(event_count), 0);
    reset = 1'b0;
    step();

    // confirm=3, three hit frames, post=5 every 3rd cycle, holdoff=10 rearm
    pulse_arm(4'd3, 16'd5, 24'd10, 1'b1);
    check("t1_armed", 32'(state), 1);
    check("t1_busy", 32'(busy), 1);
    cfg_confirm_frames = 4'd1;
    frame(1'b1);
    frame(1'b1);
    check("t1_after2", 32'(state), 1);
    frame(1'b1);
    check("t1_capture", 32'(state), 2);
    check("t1_cstart", 32'(capture_start), 1);
    check("t1_evt", 32'(event_count), 1);
    step();
    check("t1_cstart_drop", 32'(capture_start), 0);
    for (int unsigned i = 0; i < 5; i++) begin
      strobe();
      if (i == 3) check("t1_after4", 32'(state), 2);
      if (i < 4) begin
        step(); step();
      end
    end
    check("t1_readout", 32'(state), 3);
    check("t1_freeze", 32'(buf_freeze), 1);
    check("t1_req", 32'(readout_req), 1);
    pulse_readout_done();
    check("t1_holdoff", 32'(state), 4);
    check("t1_freeze_drop", 32'(buf_freeze), 0);
    check("t1_req_drop", 32'(readout_req), 0);
    for (int unsigned i = 0; i < 9; i++) begin
      step();
      check("t1_hold_stay", 32'(state), 4);
    end
    step();
    check("t1_rearmed", 32'(state), 3'd1);

    // hit, hit, miss, hit, hit, hit with the latched confirm=3
    frame(1'b1); frame(1'b1); frame(1'b0); frame(1'b1); frame(1'b1);
    check("t2_after5", 32'(state), 1);
    frame(1'b1);
    check("t2_capture", 32'(state), 2);
    check("t2_evt", 32'(event_count), 2);
    pulse_abort();
    check("t2_abort_state", 32'(state), 0);
    check("t2_abort_busy", 32'(busy), 0);
    check("t2_abort_evt", 32'(event_count), 2);

    // confirm=0, lone hit on the frame_done beat, post=0
    pulse_arm(4'd0, 16'd0, 24'd0, 1'b0);
    t_valid = 1'b1; trig_hit = 1'b1; frame_done = 1'b1;
    step();
    t_valid = 1'b0; trig_hit = 1'b0; frame_done = 1'b0;
    check("t3_capture", 32'(state), 2);
    check("t3_evt", 32'(event_count), 3);
    step();
    check("t3_readout", 32'(state), 3);
    check("t3_freeze", 32'(buf_freeze), 1);
    pulse_abort();
    check("t3_abort_state", 32'(state), 0);
    check("t3_abort_freeze", 32'(buf_freeze), 0);
    check("t3_abort_req", 32'(readout_req), 0);
    check("t3_abort_evt", 32'(event_count), 3);

    // holdoff=0 lasts one cycle; stray readout_done in ARMED is ignored
    pulse_arm(4'd1, 16'd0, 24'd0, 1'b0);
    pulse_readout_done();
    check("t4_rd_ignored", 32'(state), 1);
    arm = 1'b1; step(); arm = 1'b0;
    check("t4_arm_ignored", 32'(state), 1);
    frame(1'b1);
    check("t4_capture", 32'(state), 2);
    step();
    check("t4_readout", 32'(state), 3);
    pulse_readout_done();
    check("t4_holdoff", 32'(state), 4);
    step();
    check("t4_idle", 32'(state), 0);
    check("t4_busy", 32'(busy), 0);

    // holdoff=10 without rearm returns to IDLE
    pulse_arm(4'd1, 16'd2, 24'd10, 1'b0);
    frame(1'b1);
    strobe();
    check("t5_after1", 32'(state), 2);
    strobe();
    check("t5_readout", 32'(state), 3);
    pulse_readout_done();
    for (int unsigned i = 0; i < 9; i++) step();
    check("t5_hold_last", 32'(state), 4);
    step();
    check("t5_idle", 32'(state), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_evt", 32'(event_count), 5);

    // asynchronous reset in the middle of HOLDOFF
    pulse_arm(4'd1, 16'd0, 24'd10, 1'b1);
    frame(1'b1);
    step();
    pulse_readout_done();
    step(); step();
    check("t6_in_hold", 32'(state), 4);
    check("t6_evt", 32'(event_count), 6);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_state", 32'(state), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_evt", 32'(event_count), 0);
    check("t6_rst_freeze", 32'(buf_freeze), 0);
    step();
    reset = 1'b0;
    step(); step();
    check("t6_wait_arm", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
